alu_byte_sequencer: RTL and testbench
=====================================

// Module: alu_byte_sequencer
// PURPOSE
//  Board-level sequencer for the 32-bit ALU datapath. Collects operands A and B one byte per
//  debounced 'set' press from the 8 switches, runs one ALU operation, registers the result and
//  shows it one byte at a time on the 8 LEDs. Sits between the board I/O pins and the ALU.
//  It replaces the manual set/unlock lock scheme with a synchroniser, a debouncer and an FSM.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  cycles the synchronised 'set' must stay stable before it is accepted (board build: 500000)
// PORTS
//  clk       in   1   system clock; every flop is rising-edge
//  rst       in   1   synchronous reset, active-high
//  inp       in   8   switch byte for operand loading
//  op        in   2   ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR; sampled in EXEC
//  cin       in   1   carry-in for ADD; sampled in EXEC
//  set       in   1   raw push button, asynchronous, bouncy
//  clear     in   1   level, already clean; aborts the current operation
//  select    in   2   result byte shown on out: 00 = [7:0] ... 11 = [31:24]
//  out       out  8   result[8*select +: 8]
//  cout      out  1   registered carry-out of the last operation
//  byte_idx  out  3   index of the next byte to load; 0-3 = A, 4-7 = B
//  busy      out  1   high in EXEC
//  done      out  1   high in SHOW
// BEHAVIOUR
//  - Reset: state = LOAD; A, B, result = 0; byte_idx = 0; cout = 0; busy = 0; done = 0; out = 0.
//  - Input conditioning: 'set' passes through a 2-flop synchroniser, then the debouncer.
//    The debounced level changes only after DEBOUNCE_CYCLES identical synchronised samples.
//    set_pulse is one cycle long, generated on the debounced rising edge.
//    Press-to-pulse latency = 2 + DEBOUNCE_CYCLES + 1 cycles. A held button produces one pulse.
//  - FSM states: LOAD -> EXEC -> SHOW -> LOAD.
//  - LOAD:
//    - On set_pulse, write inp into byte byte_idx[1:0] of A (byte_idx[2] = 0) or of B (byte_idx[2] = 1).
//    - Then byte_idx increments. When the byte at index 7 is written, byte_idx wraps to 0
//      and the FSM enters EXEC on the next cycle.
//  - EXEC (exactly 1 cycle, busy = 1):
//    - Sample op and cin.
//    - ADD: {cout, result} = A + B + cin.
//    - SUB: {cout, result} = A + ~B + 1. cin is ignored; cout = 1 means no borrow.
//    - AND / OR: bitwise; cout = 0.
//    - All arithmetic is 33-bit with no saturation; overflow wraps modulo 2^32.
//    - result and cout are registered at the end of EXEC. Next state = SHOW.
//  - SHOW (done = 1): result and cout hold.
//    - The next set_pulse goes to LOAD with byte_idx = 0; inp is not written on that pulse.
//    - A and B keep their old values until overwritten.
//  - out is a combinational byte select of the registered result, valid in every state.
//    result is only updated in EXEC.
//  - set_pulse in EXEC is dropped; it is not queued.
//  - clear (any state): state = LOAD; byte_idx = 0; A = 0; B = 0. result and cout are kept.
//    The debouncer is not cleared.
//  - clear together with set_pulse in the same cycle: clear wins and no byte is written.
//  - rst mid-operation: full reset values as above, including the synchroniser and debouncer.
// STRUCTURE
//  - Shared header alu_seq_defs.vh: localparams for the op codes (OP_ADD/OP_SUB/OP_AND/OP_OR),
//    the state encodings (ST_LOAD/ST_EXEC/ST_SHOW) and the byte width 8.
//  - Sub-module button_debounce(clk, rst, raw, pulse), parameter DEBOUNCE_CYCLES.
//    Contains the synchroniser, the stability counter and the edge detector; reused for other buttons.
//  - FSM, operand registers and ALU function stay in this module; the ADD path may instantiate
//    carry_ripple_adder.
// TESTING  (DEBOUNCE_CYCLES = 4)
//  1. ADD: load A = 0x0000_00FF, B = 0x0000_0001 via 8 clean presses; op = 00, cin = 0
//     -> done = 1; select 00 -> out = 0x00; select 01 -> out = 0x01; cout = 0.
//  2. Carry and SUB: A = 0xFFFF_FFFF, B = 0x0000_0001, ADD, cin = 1 -> result 0x0000_0001, cout = 1.
//     Reload, op = 01 with A = 5, B = 7 -> result 0xFFFF_FFFE, cout = 0.
//  3. Bounce: 'set' toggles every cycle for 10 cycles, then held high for 8 cycles
//     -> exactly one set_pulse; byte_idx 0 -> 1; no pulse on release.
//  4. Clear: clear asserted after 5 bytes loaded -> byte_idx = 0, A = B = 0, previous result still on out.
//     Clear in the same cycle as a set_pulse -> no byte written.
//  5. Reset mid-op: assert rst for 1 cycle while byte_idx = 6
//     -> next cycle all outputs are 0 and state = LOAD; a subsequent full 8-byte load executes correctly.
//  6. SHOW exit: set_pulse in SHOW with inp = 0xAA -> LOAD, byte_idx = 0, A[7:0] unchanged;
//     the next pulse writes 0xAA into A[7:0].

Source files
------------

// File: rtl/alu_byte_sequencer_pkg.sv
// Shared types and the ALU function for the byte-serial ALU sequencer.
package alu_byte_sequencer_pkg;

  localparam int unsigned ByteW = 8;
  localparam int unsigned WordW = 32;

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpAnd = 2'b10,
    OpOr  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    StLoad = 2'b00,
    StExec = 2'b01,
    StShow = 2'b10
  } seq_state_e;

  // Returns {cout, result}; SUB is A + ~B + 1 so cout = 1 means no borrow.
  function automatic logic [WordW:0] alu_eval(input alu_op_e op, input logic [WordW-1:0] a,
                                              input logic [WordW-1:0] b, input logic cin);
    logic [WordW:0] r;
    r = '0;
    unique case (op)
      OpAdd: r = {1'b0, a} + {1'b0, b} + {{WordW{1'b0}}, cin};
      OpSub: r = {1'b0, a} + {1'b0, ~b} + {{WordW{1'b0}}, 1'b1};
      OpAnd: r = {1'b0, a & b};
      OpOr:  r = {1'b0, a | b};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_byte_sequencer_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and rising-edge pulse.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            sync1_q, sync2_q;
  logic            deb_q, deb_prev_q, pulse_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      pulse_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      pulse_q    <= deb_q & ~deb_prev_q;
      // Any sample that agrees with the current level restarts the stability count.
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        deb_q <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/alu_byte_sequencer.sv
// Loads two 32-bit operands a byte per button press, runs one ALU op, shows the result by byte.
module alu_byte_sequencer
  import alu_byte_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] inp,
  input  logic [1:0] op,
  input  logic       cin,
  input  logic       set,
  input  logic       clear,
  input  logic [1:0] select,
  output logic [7:0] out,
  output logic       cout,
  output logic [2:0] byte_idx,
  output logic       busy,
  output logic       done
);

  seq_state_e       state_q, state_d;
  logic [WordW-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic             cout_q, cout_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic             set_pulse;
  logic [WordW:0]   alu_res;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_set_debounce (
    .clk  (clk),
    .rst  (rst),
    .raw  (set),
    .pulse(set_pulse)
  );

  assign alu_res = alu_eval(alu_op_e'(op), a_q, b_q, cin);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    cout_d     = cout_q;
    byte_idx_d = byte_idx_q;
    if (clear) begin
      state_d    = StLoad;
      a_d        = '0;
      b_d        = '0;
      byte_idx_d = '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (set_pulse) begin
            if (byte_idx_q[2]) begin
              b_d[{byte_idx_q[1:0], 3'b000} +: ByteW] = inp;
            end else begin
              a_d[{byte_idx_q[1:0], 3'b000} +: ByteW] = inp;
            end
            byte_idx_d = byte_idx_q + 3'd1;
            if (byte_idx_q == 3'd7) begin
              state_d = StExec;
            end
          end
        end
        StExec: begin
          result_d = alu_res[WordW-1:0];
          cout_d   = alu_res[WordW];
          state_d  = StShow;
        end
        StShow: begin
          if (set_pulse) begin
            state_d    = StLoad;
            byte_idx_d = '0;
          end
        end
        default: state_d = StLoad;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLoad;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      byte_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  always_comb begin
    out = result_q[{select, 3'b000} +: ByteW];
  end

  assign cout     = cout_q;
  assign byte_idx = byte_idx_q;
  assign busy     = (state_q == StExec);
  assign done     = (state_q == StShow);

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Randomised bench for alu_byte_sequencer against a transaction-level operand/result model.
module tb_alu_byte_sequencer;

  localparam int unsigned Deb = 4;

  logic       clk = 1'b0;
  logic       rst, cin, set, clear;
  logic [7:0] inp;
  logic [1:0] op, select;
  logic [7:0] out;
  logic       cout, busy, done;
  logic [2:0] byte_idx;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: operand bytes 0-3 = A, 4-7 = B.
  logic [7:0]  m_bytes [8];
  int          m_idx;
  bit          m_show;
  logic [31:0] m_res;
  bit          m_cout;

  alu_byte_sequencer #(
    .DEBOUNCE_CYCLES(Deb)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .inp     (inp),
    .op      (op),
    .cin     (cin),
    .set     (set),
    .clear   (clear),
    .select  (select),
    .out     (out),
    .cout    (cout),
    .byte_idx(byte_idx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) m_bytes[i] = 8'h00;
    m_idx  = 0;
    m_show = 0;
    m_res  = 32'h0;
    m_cout = 0;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 8; i++) m_bytes[i] = 8'h00;
    m_idx  = 0;
    m_show = 0;
  endfunction

  function automatic void m_exec();
    longint unsigned a, b, s;
    a = {32'h0, m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
    b = {32'h0, m_bytes[7], m_bytes[6], m_bytes[5], m_bytes[4]};
    case (op)
      2'b00: begin
        s      = a + b + longint'(cin);
        m_res  = s[31:0];
        m_cout = (s >= 64'h1_0000_0000);
      end
      2'b01: begin
        s      = (a - b) & 64'hFFFF_FFFF;
        m_res  = s[31:0];
        m_cout = (a >= b);
      end
      2'b10: begin
        s      = a & b;
        m_res  = s[31:0];
        m_cout = 0;
      end
      default: begin
        s      = a | b;
        m_res  = s[31:0];
        m_cout = 0;
      end
    endcase
  endfunction

  function automatic void m_press(input logic [7:0] v);
    if (m_show) begin
      m_show = 0;
      m_idx  = 0;
    end else begin
      m_bytes[m_idx] = v;
      if (m_idx == 7) begin
        m_idx = 0;
        m_exec();
        m_show = 1;
      end else begin
        m_idx++;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_idx"}, 32'(byte_idx), 32'(m_idx));
    check({tag, "_done"}, 32'(done), 32'(m_show));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cout"}, 32'(cout), 32'(m_cout));
    for (int s = 0; s < 4; s++) begin
      select = 2'(s);
      #1;
      check({tag, "_out"}, 32'(out), 32'(m_res[8*s +: 8]));
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] exp_res, input logic exp_cout);
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    for (int s = 0; s < 4; s++) begin
      select = 2'(s);
      #1;
      check({tag, "_out"}, 32'(out), 32'(exp_res[8*s +: 8]));
    end
  endtask

  task automatic press(input logic [7:0] v, input bit bounce);
    int   pre_idx;
    bit   pre_show, wrap;
    logic level;
    inp = v;
    if (!bounce) begin
      pre_idx  = m_idx;
      pre_show = m_show;
      wrap     = !m_show && (m_idx == 7);
      set      = 1'b1;
      repeat (2 + Deb + 1) tick();
      check("lat_idx", 32'(byte_idx), 32'(pre_idx));
      check("lat_done", 32'(done), 32'(pre_show));
      tick();
      m_press(v);
      check("pulse_idx", 32'(byte_idx), 32'(m_idx));
      check("pulse_busy", 32'(busy), 32'(wrap));
      repeat (6) tick();
    end else begin
      level = 1'b1;
      repeat ($urandom_range(4, 10)) begin
        set = level;
        repeat ($urandom_range(1, Deb - 1)) tick();
        level = ~level;
      end
      set = 1'b1;
      repeat (Deb + 8) tick();
      m_press(v);
    end
    set = 1'b0;
    repeat (Deb + 8) tick();
    check_all("press");
  endtask

  task automatic load_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                         input logic c, input bit allow_bounce);
    op  = o;
    cin = c;
    if (m_show) press(8'($urandom), 1'b0);
    for (int i = 0; i < 8; i++) begin
      press((i < 4) ? a[8*i +: 8] : b[8*(i-4) +: 8],
            allow_bounce && ($urandom_range(0, 4) == 0));
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_clear();
    tick();
    check_all("clear");
  endtask

  initial begin
    rst    = 1'b1;
    set    = 1'b0;
    clear  = 1'b0;
    inp    = 8'h00;
    op     = 2'b00;
    cin    = 1'b0;
    select = 2'b00;
    m_reset();
    repeat (3) tick();
    rst = 1'b0;
    check_all("reset");

    load_op(32'h0000_00FF, 32'h0000_0001, 2'b00, 1'b0, 1'b0);
    check_result("add", 32'h0000_0100, 1'b0);
    check("add_done", 32'(done), 32'd1);

    load_op(32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b1, 1'b0);
    check_result("carry", 32'h0000_0001, 1'b1);
    load_op(32'd5, 32'd7, 2'b01, 1'b1, 1'b0);
    check_result("sub", 32'hFFFF_FFFE, 1'b0);

    press(8'h00, 1'b0);
    press(8'h3C, 1'b1);
    check("bounce_idx", 32'(byte_idx), 32'd1);

    repeat (4) press(8'($urandom), 1'b0);
    check("preclr_idx", 32'(byte_idx), 32'd5);
    do_clear();
    check_result("clr_keep", 32'hFFFF_FFFE, 1'b0);

    // Clear lands on the very cycle the set pulse reaches the FSM.
    inp = 8'h5A;
    set = 1'b1;
    repeat (2 + Deb + 1) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_clear();
    repeat (4) tick();
    set = 1'b0;
    repeat (Deb + 8) tick();
    check_all("clr_pulse");
    check("clr_pulse_idx", 32'(byte_idx), 32'd0);

    repeat (6) press(8'($urandom), 1'b0);
    check("prerst_idx", 32'(byte_idx), 32'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_reset();
    check_all("rst_mid");
    check_result("rst_mid", 32'h0, 1'b0);
    load_op($urandom, $urandom, 2'b00, 1'b1, 1'b0);

    op  = 2'b11;
    cin = 1'b0;
    press(8'hAA, 1'b0);
    check("show_exit_idx", 32'(byte_idx), 32'd0);
    check("show_exit_done", 32'(done), 32'd0);
    press(8'hAA, 1'b0);
    repeat (7) press(8'h00, 1'b0);
    check_result("show_exit", 32'h0000_00AA, 1'b0);

    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 2) == 0) do_clear();
      load_op($urandom, $urandom, 2'($urandom), 1'($urandom), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
